vx_axi_write_mem_arb: RTL and testbench
=======================================

VX_AXI_WRITE_MEM_ARB -- requirements
Module: vx_axi_write_mem_arb

Interface
Parameters:
REQ-001 AXI_DATA_WIDTH, 64, data bus width in bits; WSTRB width is AXI_DATA_WIDTH/8.
REQ-002 AXI_ADDR_WIDTH, 32, address width.
REQ-003 AXI_TID_WIDTH, 4, input transaction-ID width; the output ID is AXI_TID_WIDTH+1 bits.
REQ-004 TAG_SEL_IDX, 0, bit position in the output ID where the input-select bit is inserted.
REQ-005 WQ_DEPTH, 4, depth of the W-routing queue (power of two, at least 2).

Ports:
REQ-006 clk  in  1  clock; reset is asynchronous and active-high.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 m_axi_aw{valid,addr,id,len,size,burst,lock,cache,prot,qos,region}_N  in  1/ADDR/TID/8/3/2/2/4/3/4/4  AW request of slave input N (N = 0, 1).
REQ-009 m_axi_awready_N  out  1  AW accept to input N.
REQ-010 m_axi_w{valid,data,strb,last}_N  in  1/DATA/DATA/8/1  W beat from input N.
REQ-011 m_axi_wready_N  out  1  W accept to input N.
REQ-012 m_axi_b{valid,id,resp}_N  out  1/TID/2  B response to input N.
REQ-013 m_axi_bready_N  in  1  B accept from input N.
REQ-014 m_axi_aw{valid,addr,id,len,size,burst,lock,cache,prot,qos,region}  out  1/ADDR/TID+1/8/3/2/2/4/3/4/4  merged AW master.
REQ-015 m_axi_awready  in  1  downstream AW accept.
REQ-016 m_axi_w{valid,data,strb,last}  out  1/DATA/DATA/8/1  merged W master.
REQ-017 m_axi_wready  in  1  downstream W accept.
REQ-018 m_axi_b{valid,id,resp}  in  1/TID+1/2  downstream B response.
REQ-019 m_axi_bready  out  1  B accept to downstream.

Function
REQ-020 AW arbitration SHALL be round-robin between inputs 0 and 1; the priority pointer SHALL move to the other input after each AW handshake.
REQ-021 AW grant SHALL be withheld (m_axi_awvalid=0, both awready=0) while the W-routing queue (WQ) is full, even if a pop occurs in the same cycle.
REQ-022 Output awid SHALL be the granted input's awid with the grant index inserted at bit TAG_SEL_IDX; lower bits stay in place and upper bits shift up by one.
REQ-023 Only the granted input SHALL see awready = m_axi_awready; the other input's awready SHALL be 0.
REQ-024 Each AW handshake SHALL push the granted index into WQ.
REQ-025 While WQ is non-empty, the WQ head SHALL select the W source: m_axi_w* mirror that input, its wready = m_axi_wready, and the other input's wready = 0.
REQ-026 While WQ is empty, m_axi_wvalid and both wready SHALL be 0; W data never precedes its AW, and a push is visible at the WQ head one cycle later (no bypass).
REQ-027 A W handshake with wlast=1 SHALL pop WQ; beats without wlast SHALL NOT pop. Beat counts are not checked against awlen.
REQ-028 B routing SHALL be by m_axi_bid[TAG_SEL_IDX]: the selected input gets bvalid, and bid with that bit removed; m_axi_bready = that input's bready; the other input's bvalid = 0.
REQ-029 The AW, W and B paths SHALL operate independently within the same cycle.

Reset
REQ-030 During or after reset, WQ SHALL be empty, the round-robin pointer SHALL favour input 0, and all valid/ready outputs SHALL be 0.
REQ-031 A reset asserted mid-burst SHALL discard WQ contents and any in-flight grant without emitting further beats.

Configuration
REQ-032 With VX_AXI_WARB_AW_BUF_EN defined, the merged AW output SHALL pass through a 2-entry skid buffer: 1-cycle latency, full throughput, WQ push on input-side acceptance.
REQ-033 Without VX_AXI_WARB_AW_BUF_EN, the AW path SHALL be combinational with 0-cycle latency.

Verification
REQ-034 Both inputs assert awvalid at once, with awid_0=3 and awid_1=5, TAG_SEL_IDX=0 -> input 0 is granted first with m_axi_awid=0x06, then input 1 with m_axi_awid=0x0B.
REQ-035 Input 0 sends awlen=3 (4 beats) and input 1 sends awlen=0 -> m_axi_w shows 4 beats from input 0 then 1 beat from input 1; input 1 wready stays 0 until input 0's wlast.
REQ-036 Input 0 presents wvalid before its AW is issued -> m_axi_wvalid=0 until the cycle after the AW handshake.
REQ-037 WQ_DEPTH=4, five AWs issued with W held off -> the 5th awready stays 0 until the first wlast pops WQ.
REQ-038 m_axi_bid=0x0B with bready_1=0 -> bvalid_1=1, bid_1=5, m_axi_bready=0; bvalid_0 stays 0.
REQ-039 Reset asserted mid-burst -> all valids are 0 immediately; after release the first AW grant goes to input 0.

Source files
------------

// File: rtl/vx_axi_write_mem_arb.sv
// Two-input AXI write arbiter: round-robin AW grant, W routed by a queue of granted
// indices, B routed by the inserted ID tag. Define VX_AXI_WARB_AW_BUF_EN to add an AW skid buffer.
module vx_axi_write_mem_arb #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_TID_WIDTH  = 4,
    parameter int TAG_SEL_IDX    = 0,
    parameter int WQ_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        reset,

    // AW from input 0
    input  logic                        m_axi_awvalid_0,
    output logic                        m_axi_awready_0,
    input  logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr_0,
    input  logic [AXI_TID_WIDTH-1:0]    m_axi_awid_0,
    input  logic [7:0]                  m_axi_awlen_0,
    input  logic [2:0]                  m_axi_awsize_0,
    input  logic [1:0]                  m_axi_awburst_0,
    input  logic [1:0]                  m_axi_awlock_0,
    input  logic [3:0]                  m_axi_awcache_0,
    input  logic [2:0]                  m_axi_awprot_0,
    input  logic [3:0]                  m_axi_awqos_0,
    input  logic [3:0]                  m_axi_awregion_0,

    // AW from input 1
    input  logic                        m_axi_awvalid_1,
    output logic                        m_axi_awready_1,
    input  logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr_1,
    input  logic [AXI_TID_WIDTH-1:0]    m_axi_awid_1,
    input  logic [7:0]                  m_axi_awlen_1,
    input  logic [2:0]                  m_axi_awsize_1,
    input  logic [1:0]                  m_axi_awburst_1,
    input  logic [1:0]                  m_axi_awlock_1,
    input  logic [3:0]                  m_axi_awcache_1,
    input  logic [2:0]                  m_axi_awprot_1,
    input  logic [3:0]                  m_axi_awqos_1,
    input  logic [3:0]                  m_axi_awregion_1,

    // W from inputs
    input  logic                        m_axi_wvalid_0,
    output logic                        m_axi_wready_0,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata_0,
    input  logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb_0,
    input  logic                        m_axi_wlast_0,
    input  logic                        m_axi_wvalid_1,
    output logic                        m_axi_wready_1,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata_1,
    input  logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb_1,
    input  logic                        m_axi_wlast_1,

    // B to inputs
    output logic                        m_axi_bvalid_0,
    input  logic                        m_axi_bready_0,
    output logic [AXI_TID_WIDTH-1:0]    m_axi_bid_0,
    output logic [1:0]                  m_axi_bresp_0,
    output logic                        m_axi_bvalid_1,
    input  logic                        m_axi_bready_1,
    output logic [AXI_TID_WIDTH-1:0]    m_axi_bid_1,
    output logic [1:0]                  m_axi_bresp_1,

    // Merged master
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [AXI_TID_WIDTH:0]      m_axi_awid,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic [1:0]                  m_axi_awlock,
    output logic [3:0]                  m_axi_awcache,
    output logic [2:0]                  m_axi_awprot,
    output logic [3:0]                  m_axi_awqos,
    output logic [3:0]                  m_axi_awregion,

    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,

    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    input  logic [AXI_TID_WIDTH:0]      m_axi_bid,
    input  logic [1:0]                  m_axi_bresp
);

    localparam int OID_W = AXI_TID_WIDTH + 1;
    localparam int WQ_AW = $clog2(WQ_DEPTH);

    localparam logic [OID_W-1:0] SEL_BIT = OID_W'(1) << TAG_SEL_IDX;
    localparam logic [OID_W-1:0] LO_MASK = SEL_BIT - OID_W'(1);
    localparam logic [OID_W-1:0] HI_MASK = ~(LO_MASK | SEL_BIT);

    typedef struct packed {
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [OID_W-1:0]          id;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic [1:0]                lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
        logic [3:0]                qos;
        logic [3:0]                region;
    } aw_t;

    // ---------------- AW arbitration ----------------
    logic                     rr_q, rr_d;
    logic                     aw_req_any;
    logic                     aw_gnt;
    logic                     aw_gnt_rdy;
    logic                     aw_fire_in;
    logic [AXI_TID_WIDTH-1:0] aw_in_id;
    logic [OID_W-1:0]         aw_in_id_ext;
    aw_t                      aw_in;
    aw_t                      aw_out;

    // WQ state, declared here because AW grant depends on fullness
    logic [WQ_DEPTH-1:0] wq_mem_q, wq_mem_d;
    logic [WQ_AW:0]      wq_wr_q, wq_wr_d;
    logic [WQ_AW:0]      wq_rd_q, wq_rd_d;
    logic                wq_empty, wq_full, wq_head;
    logic                w_pop;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        aw_req_any = m_axi_awvalid_0 | m_axi_awvalid_1;
        aw_gnt     = 1'b0;
        if (m_axi_awvalid_0 && m_axi_awvalid_1) begin
            aw_gnt = rr_q;
        end else if (m_axi_awvalid_1) begin
            aw_gnt = 1'b1;
        end

        aw_in_id     = aw_gnt ? m_axi_awid_1 : m_axi_awid_0;
        aw_in_id_ext = {1'b0, aw_in_id};

        // Select bit goes in at TAG_SEL_IDX; bits above it shift up by one.
        aw_in.id     = (aw_in_id_ext & LO_MASK) | ((aw_in_id_ext << 1) & HI_MASK)
                     | (aw_gnt ? SEL_BIT : '0);
        aw_in.addr   = aw_gnt ? m_axi_awaddr_1   : m_axi_awaddr_0;
        aw_in.len    = aw_gnt ? m_axi_awlen_1    : m_axi_awlen_0;
        aw_in.size   = aw_gnt ? m_axi_awsize_1   : m_axi_awsize_0;
        aw_in.burst  = aw_gnt ? m_axi_awburst_1  : m_axi_awburst_0;
        aw_in.lock   = aw_gnt ? m_axi_awlock_1   : m_axi_awlock_0;
        aw_in.cache  = aw_gnt ? m_axi_awcache_1  : m_axi_awcache_0;
        aw_in.prot   = aw_gnt ? m_axi_awprot_1   : m_axi_awprot_0;
        aw_in.qos    = aw_gnt ? m_axi_awqos_1    : m_axi_awqos_0;
        aw_in.region = aw_gnt ? m_axi_awregion_1 : m_axi_awregion_0;
    end

`ifdef VX_AXI_WARB_AW_BUF_EN
    // Two-entry skid buffer: input side accepts whenever a slot is free.
    aw_t        buf_mem_q [2];
    aw_t        buf_mem_d [2];
    logic       buf_wr_q, buf_wr_d;
    logic       buf_rd_q, buf_rd_d;
    logic [1:0] buf_cnt_q, buf_cnt_d;
    logic       buf_pop;

    always_comb begin
        aw_gnt_rdy = !reset && !wq_full && (buf_cnt_q != 2'd2);
        aw_fire_in = aw_req_any && aw_gnt_rdy;

        m_axi_awvalid = !reset && (buf_cnt_q != 2'd0);
        aw_out        = buf_mem_q[buf_rd_q];
        buf_pop       = m_axi_awvalid && m_axi_awready;

        buf_mem_d = buf_mem_q;
        buf_wr_d  = buf_wr_q;
        buf_rd_d  = buf_rd_q;
        buf_cnt_d = buf_cnt_q;
        if (aw_fire_in) begin
            buf_mem_d[buf_wr_q] = aw_in;
            buf_wr_d            = ~buf_wr_q;
        end
        if (buf_pop) begin
            buf_rd_d = ~buf_rd_q;
        end
        case ({aw_fire_in, buf_pop})
            2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
            2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
            default: buf_cnt_d = buf_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_wr_q  <= 1'b0;
            buf_rd_q  <= 1'b0;
            buf_cnt_q <= 2'd0;
        end else begin
            buf_wr_q  <= buf_wr_d;
            buf_rd_q  <= buf_rd_d;
            buf_cnt_q <= buf_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_mem_q <= buf_mem_d;
    end
`else
    // Combinational AW path: the downstream ready reaches the granted input directly.
    always_comb begin
        aw_gnt_rdy    = !reset && !wq_full && m_axi_awready;
        aw_fire_in    = aw_req_any && aw_gnt_rdy;
        m_axi_awvalid = !reset && !wq_full && aw_req_any;
        aw_out        = aw_in;
    end
`endif

    always_comb begin
        m_axi_awready_0 = aw_gnt_rdy && !aw_gnt;
        m_axi_awready_1 = aw_gnt_rdy && aw_gnt;
        rr_d            = aw_fire_in ? ~aw_gnt : rr_q;

        m_axi_awaddr   = aw_out.addr;
        m_axi_awid     = aw_out.id;
        m_axi_awlen    = aw_out.len;
        m_axi_awsize   = aw_out.size;
        m_axi_awburst  = aw_out.burst;
        m_axi_awlock   = aw_out.lock;
        m_axi_awcache  = aw_out.cache;
        m_axi_awprot   = aw_out.prot;
        m_axi_awqos    = aw_out.qos;
        m_axi_awregion = aw_out.region;
    end

    // ---------------- W routing queue ----------------
    always_comb begin
        wq_empty = (wq_wr_q == wq_rd_q);
        wq_full  = (wq_wr_q[WQ_AW] != wq_rd_q[WQ_AW])
                && (wq_wr_q[WQ_AW-1:0] == wq_rd_q[WQ_AW-1:0]);
        wq_head  = wq_mem_q[wq_rd_q[WQ_AW-1:0]];

        wq_mem_d = wq_mem_q;
        wq_wr_d  = wq_wr_q;
        wq_rd_d  = wq_rd_q;
        if (aw_fire_in) begin
            wq_mem_d[wq_wr_q[WQ_AW-1:0]] = aw_gnt;
            wq_wr_d                      = wq_wr_q + 1'b1;
        end
        if (w_pop) begin
            wq_rd_d = wq_rd_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q    <= 1'b0;
            wq_wr_q <= '0;
            wq_rd_q <= '0;
        end else begin
            rr_q    <= rr_d;
            wq_wr_q <= wq_wr_d;
            wq_rd_q <= wq_rd_d;
        end
    end

    // NOTE: queue storage is not reset; the pointers alone define which entries are meaningful.
    always_ff @(posedge clk) begin
        wq_mem_q <= wq_mem_d;
    end

    // ---------------- W mux ----------------
    always_comb begin
        m_axi_wvalid   = 1'b0;
        m_axi_wready_0 = 1'b0;
        m_axi_wready_1 = 1'b0;
        m_axi_wdata    = wq_head ? m_axi_wdata_1 : m_axi_wdata_0;
        m_axi_wstrb    = wq_head ? m_axi_wstrb_1 : m_axi_wstrb_0;
        m_axi_wlast    = wq_head ? m_axi_wlast_1 : m_axi_wlast_0;
        if (!wq_empty && !reset) begin
            m_axi_wvalid   = wq_head ? m_axi_wvalid_1 : m_axi_wvalid_0;
            m_axi_wready_0 = !wq_head && m_axi_wready;
            m_axi_wready_1 = wq_head && m_axi_wready;
        end
        w_pop = m_axi_wvalid && m_axi_wready && m_axi_wlast;
    end

    // ---------------- B routing ----------------
    logic                     b_sel;
    logic [AXI_TID_WIDTH-1:0] b_id;

    always_comb begin
        b_sel = m_axi_bid[TAG_SEL_IDX];
        b_id  = AXI_TID_WIDTH'((m_axi_bid & LO_MASK) | ((m_axi_bid >> 1) & ~LO_MASK));

        m_axi_bvalid_0 = !reset && m_axi_bvalid && !b_sel;
        m_axi_bvalid_1 = !reset && m_axi_bvalid && b_sel;
        m_axi_bid_0    = b_id;
        m_axi_bid_1    = b_id;
        m_axi_bresp_0  = m_axi_bresp;
        m_axi_bresp_1  = m_axi_bresp;
        m_axi_bready   = !reset && (b_sel ? m_axi_bready_1 : m_axi_bready_0);
    end

endmodule

// File: tb/tb_vx_axi_write_mem_arb.sv
// Directed bench for vx_axi_write_mem_arb: AW/W scoreboards popped on downstream handshakes,
// plus direct checks of grant, blocking, B routing and reset behaviour.
module tb_vx_axi_write_mem_arb;

    logic        clk = 1'b0;
    logic        reset;

    logic        m_axi_awvalid_0, m_axi_awready_0, m_axi_awvalid_1, m_axi_awready_1;
    logic [31:0] m_axi_awaddr_0, m_axi_awaddr_1;
    logic [3:0]  m_axi_awid_0, m_axi_awid_1;
    logic [7:0]  m_axi_awlen_0, m_axi_awlen_1;
    logic [2:0]  m_axi_awsize_0, m_axi_awsize_1;
    logic [1:0]  m_axi_awburst_0, m_axi_awburst_1;
    logic [1:0]  m_axi_awlock_0, m_axi_awlock_1;
    logic [3:0]  m_axi_awcache_0, m_axi_awcache_1;
    logic [2:0]  m_axi_awprot_0, m_axi_awprot_1;
    logic [3:0]  m_axi_awqos_0, m_axi_awqos_1;
    logic [3:0]  m_axi_awregion_0, m_axi_awregion_1;

    logic        m_axi_wvalid_0, m_axi_wready_0, m_axi_wlast_0;
    logic        m_axi_wvalid_1, m_axi_wready_1, m_axi_wlast_1;
    logic [63:0] m_axi_wdata_0, m_axi_wdata_1;
    logic [7:0]  m_axi_wstrb_0, m_axi_wstrb_1;

    logic        m_axi_bvalid_0, m_axi_bready_0, m_axi_bvalid_1, m_axi_bready_1;
    logic [3:0]  m_axi_bid_0, m_axi_bid_1;
    logic [1:0]  m_axi_bresp_0, m_axi_bresp_1;

    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic [4:0]  m_axi_awid;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst, m_axi_awlock;
    logic [3:0]  m_axi_awcache;
    logic [2:0]  m_axi_awprot;
    logic [3:0]  m_axi_awqos, m_axi_awregion;

    logic        m_axi_wvalid, m_axi_wready, m_axi_wlast;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;

    logic        m_axi_bvalid, m_axi_bready;
    logic [4:0]  m_axi_bid;
    logic [1:0]  m_axi_bresp;

    int checks = 0;
    int errors = 0;

    logic [36:0] aw_exp[$];   // {awid, awaddr}
    logic [64:0] w_exp[$];    // {wlast, wdata}

    vx_axi_write_mem_arb dut (
        .clk(clk), .reset(reset),
        .m_axi_awvalid_0(m_axi_awvalid_0), .m_axi_awready_0(m_axi_awready_0),
        .m_axi_awaddr_0(m_axi_awaddr_0), .m_axi_awid_0(m_axi_awid_0),
        .m_axi_awlen_0(m_axi_awlen_0), .m_axi_awsize_0(m_axi_awsize_0),
        .m_axi_awburst_0(m_axi_awburst_0), .m_axi_awlock_0(m_axi_awlock_0),
        .m_axi_awcache_0(m_axi_awcache_0), .m_axi_awprot_0(m_axi_awprot_0),
        .m_axi_awqos_0(m_axi_awqos_0), .m_axi_awregion_0(m_axi_awregion_0),
        .m_axi_awvalid_1(m_axi_awvalid_1), .m_axi_awready_1(m_axi_awready_1),
        .m_axi_awaddr_1(m_axi_awaddr_1), .m_axi_awid_1(m_axi_awid_1),
        .m_axi_awlen_1(m_axi_awlen_1), .m_axi_awsize_1(m_axi_awsize_1),
        .m_axi_awburst_1(m_axi_awburst_1), .m_axi_awlock_1(m_axi_awlock_1),
        .m_axi_awcache_1(m_axi_awcache_1), .m_axi_awprot_1(m_axi_awprot_1),
        .m_axi_awqos_1(m_axi_awqos_1), .m_axi_awregion_1(m_axi_awregion_1),
        .m_axi_wvalid_0(m_axi_wvalid_0), .m_axi_wready_0(m_axi_wready_0),
        .m_axi_wdata_0(m_axi_wdata_0), .m_axi_wstrb_0(m_axi_wstrb_0), .m_axi_wlast_0(m_axi_wlast_0),
        .m_axi_wvalid_1(m_axi_wvalid_1), .m_axi_wready_1(m_axi_wready_1),
        .m_axi_wdata_1(m_axi_wdata_1), .m_axi_wstrb_1(m_axi_wstrb_1), .m_axi_wlast_1(m_axi_wlast_1),
        .m_axi_bvalid_0(m_axi_bvalid_0), .m_axi_bready_0(m_axi_bready_0),
        .m_axi_bid_0(m_axi_bid_0), .m_axi_bresp_0(m_axi_bresp_0),
        .m_axi_bvalid_1(m_axi_bvalid_1), .m_axi_bready_1(m_axi_bready_1),
        .m_axi_bid_1(m_axi_bid_1), .m_axi_bresp_1(m_axi_bresp_1),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awregion(m_axi_awregion),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_aw(input logic [4:0] id, input logic [31:0] addr);
        aw_exp.push_back({id, addr});
    endtask

    task automatic exp_w(input logic last, input logic [63:0] data);
        w_exp.push_back({last, data});
    endtask

    // Scoreboard: compare on every downstream handshake, sampled mid-cycle.
    logic [36:0] aw_e;
    logic [64:0] w_e;
    always @(negedge clk) begin
        if (m_axi_awvalid && m_axi_awready) begin
            if (aw_exp.size() == 0) begin
                check("aw_unexpected", {35'd0, m_axi_awid, m_axi_awaddr}, 72'd0);
            end else begin
                aw_e = aw_exp.pop_front();
                check("aw_hs", {35'd0, m_axi_awid, m_axi_awaddr}, {35'd0, aw_e});
            end
        end
        if (m_axi_wvalid && m_axi_wready) begin
            if (w_exp.size() == 0) begin
                check("w_unexpected", {7'd0, m_axi_wlast, m_axi_wdata}, 72'd0);
            end else begin
                w_e = w_exp.pop_front();
                check("w_beat", {7'd0, m_axi_wlast, m_axi_wdata}, {7'd0, w_e});
            end
        end
    end

    initial begin
        reset = 1'b1;
        {m_axi_awvalid_0, m_axi_awaddr_0, m_axi_awid_0, m_axi_awlen_0} = '0;
        {m_axi_awvalid_1, m_axi_awaddr_1, m_axi_awid_1, m_axi_awlen_1} = '0;
        {m_axi_awsize_0, m_axi_awburst_0, m_axi_awlock_0, m_axi_awcache_0} = '0;
        {m_axi_awprot_0, m_axi_awqos_0, m_axi_awregion_0} = '0;
        {m_axi_awsize_1, m_axi_awburst_1, m_axi_awlock_1, m_axi_awcache_1} = '0;
        {m_axi_awprot_1, m_axi_awqos_1, m_axi_awregion_1} = '0;
        {m_axi_wvalid_0, m_axi_wdata_0, m_axi_wlast_0} = '0;
        {m_axi_wvalid_1, m_axi_wdata_1, m_axi_wlast_1} = '0;
        m_axi_wstrb_0 = 8'hFF;
        m_axi_wstrb_1 = 8'hFF;
        m_axi_bvalid = 1'b0; m_axi_bid = '0; m_axi_bresp = '0;

        // Reset: outputs quiet even with requests pending
        m_axi_awvalid_0 = 1'b1; m_axi_awvalid_1 = 1'b1; m_axi_wvalid_0 = 1'b1;
        m_axi_bvalid = 1'b1; m_axi_bready_0 = 1'b1; m_axi_bready_1 = 1'b1;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        #2;
        check("rst_awvalid",  m_axi_awvalid,   0);
        check("rst_awready0", m_axi_awready_0, 0);
        check("rst_awready1", m_axi_awready_1, 0);
        check("rst_wvalid",   m_axi_wvalid,    0);
        check("rst_wready0",  m_axi_wready_0,  0);
        check("rst_bvalid0",  m_axi_bvalid_0,  0);
        check("rst_bready",   m_axi_bready,    0);
        m_axi_awvalid_0 = 1'b0; m_axi_awvalid_1 = 1'b0; m_axi_wvalid_0 = 1'b0;
        m_axi_bvalid = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // A: simultaneous AWs, input 0 first
        m_axi_awvalid_0 = 1'b1; m_axi_awid_0 = 4'd3; m_axi_awaddr_0 = 32'h1000; m_axi_awlen_0 = 8'd3;
        m_axi_awvalid_1 = 1'b1; m_axi_awid_1 = 4'd5; m_axi_awaddr_1 = 32'h2000; m_axi_awlen_1 = 8'd0;
        exp_aw(5'h06, 32'h1000);
        exp_aw(5'h0B, 32'h2000);
        #1;
        check("a_awid_first", m_axi_awid,      5'h06);
        check("a_awready0",   m_axi_awready_0, 1);
        check("a_awready1",   m_axi_awready_1, 0);
        tick();
        m_axi_awvalid_0 = 1'b0;
        #1;
        check("a_awid_second", m_axi_awid,      5'h0B);
        check("a_awready1_on", m_axi_awready_1, 1);
        check("a_awready0_off", m_axi_awready_0, 0);
        tick();
        m_axi_awvalid_1 = 1'b0;

        // B: 4-beat burst from input 0 then single beat from input 1
        m_axi_wvalid_1 = 1'b1; m_axi_wdata_1 = 64'hB1; m_axi_wlast_1 = 1'b1;
        for (int b = 0; b < 4; b++) begin
            m_axi_wvalid_0 = 1'b1;
            m_axi_wdata_0  = 64'hA0 + 64'(b);
            m_axi_wlast_0  = (b == 3);
            exp_w(b == 3, 64'hA0 + 64'(b));
            #1;
            check("b_w1_blocked", m_axi_wready_1, 0);
            check("b_w0_ready",   m_axi_wready_0, 1);
            tick();
        end
        m_axi_wvalid_0 = 1'b0; m_axi_wlast_0 = 1'b0;
        exp_w(1'b1, 64'hB1);
        #1;
        check("b_w1_ready", m_axi_wready_1, 1);
        tick();
        m_axi_wvalid_1 = 1'b0; m_axi_wlast_1 = 1'b0;

        // C: W presented before its AW is not forwarded
        m_axi_wvalid_0 = 1'b1; m_axi_wdata_0 = 64'hC0; m_axi_wlast_0 = 1'b1;
        exp_w(1'b1, 64'hC0);
        #1;
        check("c_wvalid_early", m_axi_wvalid,   0);
        check("c_wready_early", m_axi_wready_0, 0);
        tick();
        m_axi_awvalid_0 = 1'b1; m_axi_awid_0 = 4'd2; m_axi_awaddr_0 = 32'h3000; m_axi_awlen_0 = 8'd0;
        exp_aw(5'h04, 32'h3000);
        #1;
        check("c_no_bypass", m_axi_wvalid, 0);
        tick();
        m_axi_awvalid_0 = 1'b0;
        #1;
        check("c_wvalid_after", m_axi_wvalid, 1);
        check("c_wdata_after",  m_axi_wdata,  64'hC0);
        tick();
        m_axi_wvalid_0 = 1'b0; m_axi_wlast_0 = 1'b0;

        // D: WQ fills at 4 outstanding AWs
        m_axi_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_axi_awvalid_0 = 1'b1; m_axi_awid_0 = 4'(i); m_axi_awaddr_0 = 32'h4000 + 32'(i * 16);
            exp_aw({4'(i), 1'b0}, 32'h4000 + 32'(i * 16));
            #1;
            check("d_awready_fill", m_axi_awready_0, 1);
            tick();
        end
        m_axi_awid_0 = 4'd4; m_axi_awaddr_0 = 32'h4040;
        #1;
        check("d_full_awready", m_axi_awready_0, 0);
        check("d_full_awvalid", m_axi_awvalid,   0);
        tick();
        check("d_full_awready_hold", m_axi_awready_0, 0);
        m_axi_wready = 1'b1;
        m_axi_wvalid_0 = 1'b1; m_axi_wdata_0 = 64'hD0; m_axi_wlast_0 = 1'b1;
        exp_w(1'b1, 64'hD0);
        #1;
        check("d_pop_same_cycle", m_axi_awready_0, 0);
        tick();
        m_axi_wvalid_0 = 1'b0;
        exp_aw(5'h08, 32'h4040);
        #1;
        check("d_after_pop", m_axi_awready_0, 1);
        tick();
        m_axi_awvalid_0 = 1'b0;
        for (int i = 1; i < 5; i++) begin
            m_axi_wvalid_0 = 1'b1; m_axi_wdata_0 = 64'hD0 + 64'(i); m_axi_wlast_0 = 1'b1;
            exp_w(1'b1, 64'hD0 + 64'(i));
            tick();
        end
        m_axi_wvalid_0 = 1'b0; m_axi_wlast_0 = 1'b0;

        // E: round-robin pointer now favours input 1
        m_axi_awvalid_0 = 1'b1; m_axi_awid_0 = 4'hA; m_axi_awaddr_0 = 32'h5000;
        m_axi_awvalid_1 = 1'b1; m_axi_awid_1 = 4'h7; m_axi_awaddr_1 = 32'h6000;
        exp_aw(5'h0F, 32'h6000);
        exp_aw(5'h14, 32'h5000);
        #1;
        check("e_rr_awid1",    m_axi_awid,      5'h0F);
        check("e_rr_awready0", m_axi_awready_0, 0);
        tick();
        m_axi_awvalid_1 = 1'b0;
        #1;
        check("e_rr_awid0", m_axi_awid, 5'h14);
        tick();
        m_axi_awvalid_0 = 1'b0;
        m_axi_wvalid_0 = 1'b1; m_axi_wdata_0 = 64'hE0; m_axi_wlast_0 = 1'b1;
        m_axi_wvalid_1 = 1'b1; m_axi_wdata_1 = 64'hE1; m_axi_wlast_1 = 1'b1;
        exp_w(1'b1, 64'hE1);
        exp_w(1'b1, 64'hE0);
        #1;
        check("e_w_head1_w0", m_axi_wready_0, 0);
        check("e_w_head1_w1", m_axi_wready_1, 1);
        tick();
        m_axi_wvalid_1 = 1'b0;
        #1;
        check("e_w_head0_w0", m_axi_wready_0, 1);
        tick();
        m_axi_wvalid_0 = 1'b0; m_axi_wlast_0 = 1'b0; m_axi_wlast_1 = 1'b0;

        // F: B routing by tag bit
        m_axi_bvalid = 1'b1; m_axi_bid = 5'h0B; m_axi_bresp = 2'd2;
        m_axi_bready_0 = 1'b1; m_axi_bready_1 = 1'b0;
        #1;
        check("f_bvalid1", m_axi_bvalid_1, 1);
        check("f_bid1",    m_axi_bid_1,    4'd5);
        check("f_bresp1",  m_axi_bresp_1,  2'd2);
        check("f_bready_low", m_axi_bready, 0);
        check("f_bvalid0", m_axi_bvalid_0, 0);
        m_axi_bready_1 = 1'b1;
        #1;
        check("f_bready_high", m_axi_bready, 1);
        m_axi_bid = 5'h06; m_axi_bresp = 2'd1; m_axi_bready_0 = 1'b0;
        #1;
        check("f_bvalid0_sel", m_axi_bvalid_0, 1);
        check("f_bid0",        m_axi_bid_0,    4'd3);
        check("f_bvalid1_off", m_axi_bvalid_1, 0);
        check("f_bready0_low", m_axi_bready,   0);
        m_axi_bvalid = 1'b0;
        tick();

        // G: reset mid-burst
        m_axi_awvalid_0 = 1'b1; m_axi_awid_0 = 4'd1; m_axi_awaddr_0 = 32'h7000; m_axi_awlen_0 = 8'd3;
        exp_aw(5'h02, 32'h7000);
        tick();
        m_axi_awvalid_0 = 1'b0;
        for (int b = 0; b < 2; b++) begin
            m_axi_wvalid_0 = 1'b1; m_axi_wdata_0 = 64'hF0 + 64'(b); m_axi_wlast_0 = 1'b0;
            exp_w(1'b0, 64'hF0 + 64'(b));
            tick();
        end
        m_axi_wdata_0 = 64'hF2;
        m_axi_awvalid_0 = 1'b1; m_axi_awid_0 = 4'd6; m_axi_awaddr_0 = 32'h8000;
        m_axi_awvalid_1 = 1'b1; m_axi_awid_1 = 4'd9; m_axi_awaddr_1 = 32'h9000;
        reset = 1'b1;
        #1;
        check("g_rst_wvalid",   m_axi_wvalid,    0);
        check("g_rst_wready0",  m_axi_wready_0,  0);
        check("g_rst_awvalid",  m_axi_awvalid,   0);
        check("g_rst_awready0", m_axi_awready_0, 0);
        tick();
        reset = 1'b0;
        exp_aw(5'h0C, 32'h8000);
        #1;
        check("g_post_awid",    m_axi_awid,      5'h0C);
        check("g_post_awready1", m_axi_awready_1, 0);
        check("g_post_wvalid",  m_axi_wvalid,    0);
        tick();
        m_axi_wvalid_0 = 1'b0;
        m_axi_awvalid_0 = 1'b0;
        exp_aw(5'h13, 32'h9000);
        #1;
        check("g_post_awid1", m_axi_awid, 5'h13);
        tick();
        m_axi_awvalid_1 = 1'b0;
        tick();
        tick();

        check("aw_sb_drained", 72'(aw_exp.size()), 0);
        check("w_sb_drained",  72'(w_exp.size()),  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
